led_seq_core: RTL and testbench
===============================

Name: led_seq_core

Overview:
- Parametrised, program-driven LED pattern sequencer, successor to the fixed 8-bit pattern/jump core.
- Fetches instructions from an external synchronous-read program memory (RAM/ROM) and drives a PAT_W-bit LED pattern.
- Supports timed display, unconditional jump, counted loop and halt, plus a run/pause control.
- Sits between the program memory and the board LED pins.

Parameters:
- PAT_W, 8, LED pattern width; must be >= ADDR_W.
- ADDR_W, 8, program address width.
- ARG_W, 8, duration/loop-count field width.
- TICK_DIV, 3125000, clock cycles per display tick (50 MHz/16); must be >= 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = sequencer advances, 0 = paused.
- addrRd  out  ADDR_W  program memory read address; registered.
- dataRd  in  2+PAT_W+ARG_W  instruction word; valid one cycle after addrRd changes.
- outPattern  out  PAT_W  LED drive; registered.
- halted  out  1  high while in HALT state.

Behaviour:
- Instruction format: op = dataRd[MSB:MSB-1]; DATA = next PAT_W bits; ARG = low ARG_W bits.
- Jump/loop target = DATA[ADDR_W-1:0].
- Opcodes: 0 SHOW, 1 JUMP, 2 LOOP, 3 HALT.
- Reset values: addrRd=0, pc=0, outPattern=0, halted=0, state=FETCH, loop_armed=0, loop_cnt=0, hold_cnt=0, prescaler=0.
- Prescaler:
  - Free-running, counts 0..TICK_DIV-1 regardless of run.
  - tick=1 for one cycle when count==TICK_DIV-1, then count wraps to 0.
- FSM advances only when run=1. With run=0, all state, pc, counters and outPattern hold; the prescaler keeps running.
- addrRd always equals pc, registered.
- FETCH: one cycle waiting for memory data -> EXEC.
- EXEC, decode dataRd:
  - SHOW: outPattern<=DATA; hold_cnt<=ARG; -> HOLD.
  - JUMP: pc<=target; -> FETCH.
  - LOOP, not armed: loop_armed<=1; effective count = ARG.
  - LOOP, armed: effective count = loop_cnt.
  - LOOP resolution: if effective count != 0, loop_cnt<=count-1 and pc<=target. Otherwise loop_armed<=0 and pc<=pc+1. Then -> FETCH.
  - LOOP net effect: body runs ARG+1 times; ARG=0 falls straight through.
  - HALT: halted<=1; -> HALT_ST.
- HOLD: on tick & run, if hold_cnt==0 then pc<=pc+1 and -> FETCH; else hold_cnt<=hold_cnt-1.
  - Pattern is shown for ARG+1 ticks; the first tick may be partial.
- HALT_ST: terminal. outPattern holds its last value; halted=1; left only by rst.
- pc+1 wraps from 2^ADDR_W-1 to 0.
- Single loop register; nested LOOPs are not supported (inner use clobbers outer).
- outPattern changes only on SHOW execution or reset.
- rst in any state, including mid-HOLD or mid-LOOP, restores the reset values on the next edge. Fetch then restarts at address 0.
- tick arriving while run=0 is lost; it is not queued.

Optional Feature:
- Macro: LEDSEQ_PWM_EN.
- When defined:
  - Extra port: duty  in  4  brightness.
  - Internal 4-bit free-running PWM counter, reset to 0.
  - LED output = outPattern_reg & {PAT_W{pwm_cnt < duty}}.
  - duty=0 gives all LEDs off; duty=15 gives 15/16 on.
  - halted and FSM behaviour are unchanged.
- When undefined: no duty port; outPattern is the raw register.

Test Plan:
- TICK_DIV=4; program {SHOW 0xA5 ARG=2, SHOW 0x5A ARG=0, JUMP 0} -> after reset, outPattern=0xA5 for 3 ticks, then 0x5A for 1 tick, then 0xA5 again; addrRd sequence 0,1,2,0.
- Program {SHOW 0x01 ARG=0, LOOP target=0 ARG=2, SHOW 0xFF ARG=0, HALT} -> 0x01 shown 3 times, then 0xFF; halted=1 with outPattern=0xFF held indefinitely.
- Program {LOOP target=5 ARG=0, SHOW 0x3C ARG=0, HALT} -> falls through with no jump to 5; 0x3C shown; halted=1.
- Drop run to 0 mid-HOLD for 20 cycles -> outPattern, addrRd and hold countdown frozen; after run=1 the remaining ticks complete normally.
- ADDR_W=2, four SHOW words with distinct patterns and no JUMP -> after address 3, addrRd wraps to 0 and the pattern sequence repeats.
- Assert rst for 1 cycle mid-LOOP (loop_armed=1) -> next cycle addrRd=0, outPattern=0, halted=0, loop disarmed, so the first LOOP executes its full ARG+1 iterations again. With LEDSEQ_PWM_EN and duty=8, each LED is on exactly 8 of every 16 cycles.

Source files
------------

// File: rtl/led_seq_core_if.sv
// led_seq_core_if: program-memory read bus between led_seq_core and its RAM/ROM.
// The sequencer drives the address; the memory returns the word one cycle later.
interface led_seq_core_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 18
);
   logic [ADDR_W-1:0]  addrRd;
   logic [INSTR_W-1:0] dataRd;

   modport master (output addrRd, input dataRd);
   modport slave  (input addrRd, output dataRd);
endinterface

// File: rtl/led_seq_core.sv
// led_seq_core: program-driven LED pattern sequencer (SHOW / JUMP / LOOP / HALT) fed from a
// synchronous-read program memory. Define LEDSEQ_PWM_EN to add a 4-bit duty brightness input.
module led_seq_core #(
   parameter int PAT_W    = 8,
   parameter int ADDR_W   = 8,
   parameter int ARG_W    = 8,
   parameter int TICK_DIV = 3125000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
`ifdef LEDSEQ_PWM_EN
   input  logic [3:0]       duty,
`endif
   led_seq_core_if.master   mem,
   output logic [PAT_W-1:0] outPattern,
   output logic             halted
);
   localparam int INSTR_W = 2 + PAT_W + ARG_W;
   localparam int PRE_W   = $clog2(TICK_DIV);

   typedef enum logic [1:0] {FETCH, EXEC, HOLD, HALT_ST} state_t;
   typedef enum logic [1:0] {OP_SHOW, OP_JUMP, OP_LOOP, OP_HALT} op_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic [PAT_W-1:0]  r_pattern, w_pattern_nxt;
   logic              r_halted, w_halted_nxt;
   logic              r_loop_armed, w_loop_armed_nxt;
   logic [ARG_W-1:0]  r_loop_cnt, w_loop_cnt_nxt;
   logic [ARG_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
   logic [PRE_W-1:0]  r_presc;

   op_t               w_op;
   logic [PAT_W-1:0]  w_data;
   logic [ARG_W-1:0]  w_arg;
   logic [ARG_W-1:0]  w_loop_eff;
   logic [ADDR_W-1:0] w_target;
   logic [ADDR_W-1:0] w_pc_inc;
   logic              w_tick;

   assign w_op       = op_t'(mem.dataRd[INSTR_W-1 -: 2]);
   assign w_data     = mem.dataRd[INSTR_W-3 -: PAT_W];
   assign w_arg      = mem.dataRd[ARG_W-1:0];
   assign w_target   = w_data[ADDR_W-1:0];
   assign w_pc_inc   = r_pc + 1'b1;
   assign w_tick     = (r_presc == PRE_W'(TICK_DIV - 1));
   // A LOOP seen for the first time takes its count from the word; later passes use the register.
   assign w_loop_eff = r_loop_armed ? r_loop_cnt : w_arg;

   // Prescaler runs regardless of run, so ticks that arrive while paused are simply lost.
   always_ff @(posedge clk) begin
      if (rst)         r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (run) begin
         case (r_state)
            FETCH: w_state_nxt = EXEC;
            EXEC: begin
               case (w_op)
                  OP_SHOW: w_state_nxt = HOLD;
                  OP_JUMP: w_state_nxt = FETCH;
                  OP_LOOP: w_state_nxt = FETCH;
                  OP_HALT: w_state_nxt = HALT_ST;
               endcase
            end
            HOLD:    if (w_tick && r_hold_cnt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // NOTE: every output of this block gets a hold-value default first, so no latch is inferred.
   always_comb begin
      w_pc_nxt         = r_pc;
      w_pattern_nxt    = r_pattern;
      w_halted_nxt     = r_halted;
      w_loop_armed_nxt = r_loop_armed;
      w_loop_cnt_nxt   = r_loop_cnt;
      w_hold_cnt_nxt   = r_hold_cnt;
      if (run) begin
         case (r_state)
            EXEC: begin
               case (w_op)
                  OP_SHOW: begin
                     w_pattern_nxt  = w_data;
                     w_hold_cnt_nxt = w_arg;
                  end
                  OP_JUMP: w_pc_nxt = w_target;
                  OP_LOOP: begin
                     w_loop_armed_nxt = (w_loop_eff != '0);
                     if (w_loop_eff != '0) begin
                        w_loop_cnt_nxt = w_loop_eff - 1'b1;
                        w_pc_nxt       = w_target;
                     end else begin
                        w_pc_nxt       = w_pc_inc;
                     end
                  end
                  OP_HALT: w_halted_nxt = 1'b1;
               endcase
            end
            HOLD: begin
               if (w_tick) begin
                  if (r_hold_cnt == '0) w_pc_nxt       = w_pc_inc;
                  else                  w_hold_cnt_nxt = r_hold_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= '0;
         r_pattern    <= '0;
         r_halted     <= 1'b0;
         r_loop_armed <= 1'b0;
         r_loop_cnt   <= '0;
         r_hold_cnt   <= '0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_pattern    <= w_pattern_nxt;
         r_halted     <= w_halted_nxt;
         r_loop_armed <= w_loop_armed_nxt;
         r_loop_cnt   <= w_loop_cnt_nxt;
         r_hold_cnt   <= w_hold_cnt_nxt;
      end
   end

   assign mem.addrRd = r_pc;
   assign halted     = r_halted;

`ifdef LEDSEQ_PWM_EN
   logic [3:0] r_pwm_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_pwm_cnt <= '0;
      else     r_pwm_cnt <= r_pwm_cnt + 1'b1;
   end

   assign outPattern = r_pattern & {PAT_W{r_pwm_cnt < duty}};
`else
   assign outPattern = r_pattern;
`endif
endmodule

// File: tb/tb_led_seq_core.sv
// tb_led_seq_core: scoreboard bench for led_seq_core; expected (addr, pattern, halted, ticks)
// events are queued per program and compared whenever the observed DUT state changes.
module tb_led_seq_core;
   localparam int PAT_W = 8;
   localparam int ARG_W = 8;
   localparam int TD    = 4;
   localparam int IW    = 2 + PAT_W + ARG_W;
   localparam logic [1:0] SHOW = 2'd0, JUMP = 2'd1, LOOP = 2'd2, HALT = 2'd3;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] pat;
      logic       halt;
      bit         chk_t;
      int         ticks;
   } evt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b1;
   always #5 clk = ~clk;

   led_seq_core_if #(.ADDR_W(8), .INSTR_W(IW)) mem1 ();
   led_seq_core_if #(.ADDR_W(2), .INSTR_W(IW)) mem2 ();

   logic [IW-1:0]    prog1 [256];
   logic [IW-1:0]    prog2 [4];
   logic [PAT_W-1:0] pat1, pat2, vpat1, vpat2;
   logic             halt1, halt2;

   always @(posedge clk) mem1.dataRd <= prog1[mem1.addrRd];
   always @(posedge clk) mem2.dataRd <= prog2[mem2.addrRd];

`ifdef LEDSEQ_PWM_EN
   logic [3:0] duty = 4'd8;
`endif

   led_seq_core #(.PAT_W(PAT_W), .ADDR_W(8), .ARG_W(ARG_W), .TICK_DIV(TD)) u_dut1 (
      .clk(clk), .rst(rst), .run(run),
`ifdef LEDSEQ_PWM_EN
      .duty(duty),
`endif
      .mem(mem1), .outPattern(pat1), .halted(halt1));

   led_seq_core #(.PAT_W(PAT_W), .ADDR_W(2), .ARG_W(ARG_W), .TICK_DIV(TD)) u_dut2 (
      .clk(clk), .rst(rst), .run(run),
`ifdef LEDSEQ_PWM_EN
      .duty(duty),
`endif
      .mem(mem2), .outPattern(pat2), .halted(halt2));

   // Observe the undimmed pattern so the event monitor is independent of the dimmer.
`ifdef LEDSEQ_PWM_EN
   assign vpat1 = u_dut1.r_pattern;
   assign vpat2 = u_dut2.r_pattern;
`else
   assign vpat1 = pat1;
   assign vpat2 = pat2;
`endif

   logic       sel = 1'b0;
   logic [7:0] m_addr, m_pat;
   logic       m_halt;
   assign m_addr = sel ? {6'b0, mem2.addrRd} : mem1.addrRd;
   assign m_pat  = sel ? vpat2 : vpat1;
   assign m_halt = sel ? halt2 : halt1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference tick: one cycle in TD, restarted by reset.
   int tb_presc = 0;
   always @(posedge clk) begin
      if (rst) tb_presc <= 0;
      else     tb_presc <= (tb_presc == TD - 1) ? 0 : tb_presc + 1;
   end

   evt_t        sb_q [$];
   bit          mon_en   = 1'b0;
   logic [16:0] prev     = '0;
   int          tick_cnt = 0;

   always @(negedge clk) begin : monitor
      evt_t        e;
      logic [16:0] cur;
      if (mon_en) begin
         cur = {m_addr, m_pat, m_halt};
         if (cur !== prev) begin
            if (sb_q.size() == 0) begin
               check("extra_evt", cur, prev);
            end else begin
               e = sb_q.pop_front();
               check("evt_addr", m_addr, e.addr);
               check("evt_pat", m_pat, e.pat);
               check("evt_halt", m_halt, e.halt);
               if (e.chk_t) check("hold_ticks", tick_cnt, e.ticks);
            end
            prev     = cur;
            tick_cnt = 0;
         end
         if (run && tb_presc == TD - 1) tick_cnt++;
      end
   end

   function automatic logic [IW-1:0] ins(input logic [1:0] op, input logic [7:0] d,
                                        input logic [7:0] a);
      return {op, d, a};
   endfunction

   task automatic push(input logic [7:0] a, input logic [7:0] p, input logic h,
                       input bit ct, input int t);
      evt_t e;
      e.addr = a; e.pat = p; e.halt = h; e.chk_t = ct; e.ticks = t;
      sb_q.push_back(e);
   endtask

   task automatic do_reset(input logic s);
      mon_en = 1'b0;
      sb_q.delete();
      sel = s;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_addr", m_addr, 0);
      check("rst_pat", m_pat, 0);
      check("rst_halt", m_halt, 0);
      rst      = 1'b0;
      prev     = '0;
      tick_cnt = 0;
      mon_en   = 1'b1;
   endtask

   task automatic wait_left(input int left, input int budget);
      int n = 0;
      while (sb_q.size() > left && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      check("evt_timeout", sb_q.size(), left);
   endtask

   task automatic load_p1();
      for (int i = 0; i < 256; i++) prog1[i] = ins(HALT, 8'h00, 8'h00);
      prog1[0] = ins(SHOW, 8'hA5, 8'd2);
      prog1[1] = ins(SHOW, 8'h5A, 8'd0);
      prog1[2] = ins(JUMP, 8'h00, 8'd0);
   endtask

   task automatic push_p1();
      push(8'd0, 8'hA5, 1'b0, 1'b0, 0);
      push(8'd1, 8'hA5, 1'b0, 1'b1, 3);
      push(8'd1, 8'h5A, 1'b0, 1'b0, 0);
      push(8'd2, 8'h5A, 1'b0, 1'b1, 1);
      push(8'd0, 8'h5A, 1'b0, 1'b0, 0);
      push(8'd0, 8'hA5, 1'b0, 1'b0, 0);
      push(8'd1, 8'hA5, 1'b0, 1'b1, 3);
   endtask

   task automatic push_p2();
      push(8'd0, 8'h01, 1'b0, 1'b0, 0);
      push(8'd1, 8'h01, 1'b0, 1'b1, 1);
      push(8'd0, 8'h01, 1'b0, 1'b0, 0);
      push(8'd1, 8'h01, 1'b0, 1'b0, 0);
      push(8'd0, 8'h01, 1'b0, 1'b0, 0);
      push(8'd1, 8'h01, 1'b0, 1'b0, 0);
      push(8'd2, 8'h01, 1'b0, 1'b0, 0);
      push(8'd2, 8'hFF, 1'b0, 1'b0, 0);
      push(8'd3, 8'hFF, 1'b0, 1'b1, 1);
      push(8'd3, 8'hFF, 1'b1, 1'b0, 0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) prog2[i] = ins(HALT, 8'h00, 8'h00);

      // Show / jump program with exact hold lengths.
      load_p1();
      do_reset(1'b0);
      push_p1();
      wait_left(0, 200);

      // Pause mid-hold: nothing moves, remaining ticks complete afterwards.
      do_reset(1'b0);
      push_p1();
      wait_left(6, 50);
      repeat (3) @(posedge clk);
      @(posedge clk); #1 run = 1'b0;
      repeat (20) @(negedge clk);
      check("pause_addr", mem1.addrRd, 8'd0);
      check("pause_pat", vpat1, 8'hA5);
      check("pause_halt", halt1, 1'b0);
      @(posedge clk); #1 run = 1'b1;
      wait_left(0, 200);

      // Counted loop then halt; halt must persist.
      for (int i = 0; i < 256; i++) prog1[i] = ins(HALT, 8'h00, 8'h00);
      prog1[0] = ins(SHOW, 8'h01, 8'd0);
      prog1[1] = ins(LOOP, 8'h00, 8'd2);
      prog1[2] = ins(SHOW, 8'hFF, 8'd0);
      prog1[3] = ins(HALT, 8'h00, 8'd0);
      do_reset(1'b0);
      push_p2();
      wait_left(0, 300);
      repeat (40) @(negedge clk);
      check("halt_hold", halt1, 1'b1);
      check("halt_pat", pat1, 8'hFF);

      // Reset while the loop is armed: loop restarts with full iteration count.
      do_reset(1'b0);
      push_p2();
      wait_left(7, 100);
      do_reset(1'b0);
      push_p2();
      wait_left(0, 300);

      // LOOP with ARG=0 falls through.
      for (int i = 0; i < 256; i++) prog1[i] = ins(HALT, 8'h00, 8'h00);
      prog1[0] = ins(LOOP, 8'h05, 8'd0);
      prog1[1] = ins(SHOW, 8'h3C, 8'd0);
      prog1[2] = ins(HALT, 8'h00, 8'd0);
      do_reset(1'b0);
      push(8'd1, 8'h00, 1'b0, 1'b0, 0);
      push(8'd1, 8'h3C, 1'b0, 1'b0, 0);
      push(8'd2, 8'h3C, 1'b0, 1'b1, 1);
      push(8'd2, 8'h3C, 1'b1, 1'b0, 0);
      wait_left(0, 100);
      repeat (30) @(negedge clk);
      check("fall_halt", halt1, 1'b1);

      // Two-bit address wraps 3 -> 0.
      prog2[0] = ins(SHOW, 8'h11, 8'd0);
      prog2[1] = ins(SHOW, 8'h22, 8'd0);
      prog2[2] = ins(SHOW, 8'h44, 8'd0);
      prog2[3] = ins(SHOW, 8'h88, 8'd0);
      do_reset(1'b1);
      push(8'd0, 8'h11, 1'b0, 1'b0, 0);
      push(8'd1, 8'h11, 1'b0, 1'b1, 1);
      push(8'd1, 8'h22, 1'b0, 1'b0, 0);
      push(8'd2, 8'h22, 1'b0, 1'b1, 1);
      push(8'd2, 8'h44, 1'b0, 1'b0, 0);
      push(8'd3, 8'h44, 1'b0, 1'b1, 1);
      push(8'd3, 8'h88, 1'b0, 1'b0, 0);
      push(8'd0, 8'h88, 1'b0, 1'b1, 1);
      push(8'd0, 8'h11, 1'b0, 1'b0, 0);
      push(8'd1, 8'h11, 1'b0, 1'b1, 1);
      wait_left(0, 200);

`ifdef LEDSEQ_PWM_EN
      // Dimmer: duty=8 lights half of any 16-cycle window, duty=0 none.
      begin
         int on_cnt;
         load_p1();
         duty = 4'd8;
         do_reset(1'b0);
         mon_en = 1'b0;
         repeat (2) @(negedge clk);
         on_cnt = 0;
         repeat (16) begin
            if (pat1 != '0) on_cnt++;
            @(negedge clk);
         end
         check("pwm_duty8", on_cnt, 8);
         duty   = 4'd0;
         on_cnt = 0;
         repeat (16) begin
            @(negedge clk);
            if (pat1 != '0) on_cnt++;
         end
         check("pwm_duty0", on_cnt, 0);
      end
`endif

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
